dmem_banked: RTL
================

Name: dmem_banked

Overview:
- Parametrised data memory for the core's load/store stage, next generation of the single-word data memory.
- Adds the following over the single-word version:
  - configurable depth
  - byte-lane (byte/half/word) stores
  - sign/zero-extended sized loads
  - range checking
  - a valid/ready request/response handshake with a one-entry response buffer, so the pipeline can stall the response.
- Sits between the execute/mem stage and the storage array. It is word-organised internally and byte-addressed externally.

Parameters:
- DEPTH, 2048, number of 32-bit words; must be a power of two.
- ADDR_W, 32, width of the byte address on req_addr.
- INIT_FILE, "", hex file loaded with $readmemh at elaboration when non-empty; otherwise contents are undefined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_wdata  input  32  store data; the operand sits in the low bits (byte in [7:0], half in [15:0])
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  access fault (range, size or alignment)

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not reset.
  - A response pending when rst asserts is discarded; an in-flight request is dropped with no write.
- req_ready = !rsp_valid || rsp_ready (combinational). The request is accepted at the rising edge where req_valid && req_ready.
- Latency: a request accepted at edge N produces rsp_valid=1 after edge N. Throughput is 1 request/cycle when rsp_ready stays high.
- Response hold: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable and req_ready=0.
- Consumption: rsp_valid clears at the edge where rsp_ready=1, unless a new request is accepted at the same edge, in which case the new response replaces it.
- Addressing:
  - word index = req_addr[log2(DEPTH)+1:2]
  - lane = req_addr[1:0]
- Error conditions (rsp_err=1, no memory write, rsp_rdata=0):
  - req_addr >= DEPTH*4 (out of range)
  - req_size==3
  - misalignment when DMEM_MISALIGN_TRAP_EN is defined: half with addr[0]=1, or word with addr[1:0]!=0
- Stores:
  - Only the selected lanes are written at the accept edge:
    - byte writes lane addr[1:0]
    - half writes lanes {addr[1],0}+{0,1}
    - word writes all four lanes
  - Response: rsp_err as computed, rsp_rdata=0.
- Loads:
  - The word is read at the accept edge.
  - The selected byte/half is shifted to bit 0, then sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
- Read-after-write: a store accepted at edge N followed by a load to the same word accepted at edge N+1 returns the updated data. No bypass is needed beyond this; same-edge conflicts cannot occur.
- Edge cases:
  - rsp_ready asserted with rsp_valid=0 has no effect.
  - req_valid dropped while req_ready=0 is legal; nothing is accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned half/word accesses return rsp_err=1, perform no write and return rdata 0.
- Undefined: the low address bits are forced aligned before access:
  - half ignores addr[0]
  - word ignores addr[1:0]
  - rsp_err is raised only for range/size faults.

Test Plan:
- Reset mid-response: store word 0xDEADBEEF to 0x10, hold rsp_ready=0, assert rst → rsp_valid=0 immediately; after release, word load of 0x10 returns 0xDEADBEEF.
- Byte store 0xA5 to 0x21, then loads of 0x21:
  - signed byte → 0xFFFFFFA5
  - unsigned byte → 0x000000A5
  - word at 0x20 shows only byte 1 changed
- Half store 0x8001 to 0x42, then signed half load → 0xFFFF8001, unsigned → 0x00008001. Back-to-back accept, rsp_valid each cycle with rsp_ready=1.
- Backpressure: issue 3 loads with rsp_ready low for 4 cycles after the first → req_ready=0, first rsp_rdata held stable, no request lost; responses arrive in order after release.
- Out-of-range: word store to DEPTH*4 → rsp_err=1, rdata 0, and a word load of address 0 is unchanged. req_size=3 → rsp_err=1.
- Misaligned word store 0x12345678 to 0x06:
  - with DMEM_MISALIGN_TRAP_EN → rsp_err=1, memory unchanged
  - without it → word 0x04 becomes 0x12345678, rsp_err=0

Source files
------------

// File: rtl/dmem_banked.sv
// Byte-addressed, word-organised data memory with sized loads/stores and a one-entry response buffer.
// Optional: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_banked #(
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      rd_word;
    size_e            req_sz;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             fault;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;

    // Captured load context used to format the registered read word.
    logic             ld_ok;
    logic [1:0]       r_lane;
    size_e            r_size;
    logic             r_uns;

    assign req_sz    = size_e'(req_size);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fault     = ((req_addr >> (IDX_W + 2)) != '0) || (req_sz == SZ_BAD);
        lane      = req_addr[1:0];
        be        = 4'b0000;
        wdata_rep = req_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((req_sz == SZ_HALF && req_addr[0]) || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00))
            fault = 1'b1;
`else
        if (req_sz == SZ_HALF) lane = {req_addr[1], 1'b0};
        if (req_sz == SZ_WORD) lane = 2'b00;
`endif
        case (req_sz)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // NOTE: the storage array and its read register carry no reset; only the handshake state is reset.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            if (req_we && !fault) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
            rd_word <= mem[idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ld_ok     <= 1'b0;
            r_lane    <= 2'b00;
            r_size    <= SZ_BYTE;
            r_uns     <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= fault;
            ld_ok     <= !req_we && !fault;
            r_lane    <= lane;
            r_size    <= req_sz;
            r_uns     <= req_unsigned;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // The read word is stable until the next accept, so the formatted data holds under backpressure.
    logic [31:0] shifted;
    always_comb begin
        shifted   = rd_word >> {r_lane, 3'b000};
        rsp_rdata = '0;
        if (ld_ok) begin
            case (r_size)
                SZ_BYTE: rsp_rdata = {{24{shifted[7] & ~r_uns}}, shifted[7:0]};
                SZ_HALF: rsp_rdata = {{16{shifted[15] & ~r_uns}}, shifted[15:0]};
                SZ_WORD: rsp_rdata = rd_word;
                default: rsp_rdata = '0;
            endcase
        end
    end

endmodule
